// File: rtl/subsys_host.sv
// Host-side job controller for the systolic subsystem: streams M operand beats into
// the subsystem input FIFO and drains M result beats from its output FIFO.
module subsys_host #(
  parameter int DIN_WIDTH = 8,
  parameter int N         = 4,
  parameter int BUS_WIDTH = 2 * DIN_WIDTH * N
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           m_len_minus_one,
  output logic                 busy,
  output logic                 done,
  input  logic [BUS_WIDTH-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [BUS_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [7:0]           M_minus_one,
  output logic [BUS_WIDTH-1:0] din,
  output logic                 wr_fifo,
  input  logic                 in_fifo_full,
  output logic                 rd_fifo,
  input  logic [BUS_WIDTH-1:0] dout,
  input  logic                 out_fifo_empty
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t     state;
  logic       rd_pend;
  logic [8:0] load_cnt;
  logic [8:0] rd_cnt;
  logic [8:0] del_cnt;
  logic [8:0] m_len;
  logic [8:0] del_next;
  logic       active;
  logic       xfer;
  logic       last_push;

  // 9-bit counters so a 256-beat job never wraps.
  assign m_len     = {1'b0, M_minus_one} + 9'd1;
  assign active    = (state == LOAD) || (state == DRAIN);
  assign xfer      = m_valid & m_ready;
  assign del_next  = del_cnt + {8'd0, xfer};

  assign s_ready   = (state == LOAD) & ~in_fifo_full;
  assign wr_fifo   = s_valid & s_ready;
  assign din       = s_data;
  assign last_push = wr_fifo && ((load_cnt + 9'd1) == m_len);

  // A pop is only issued when the output register is guaranteed free on the capture edge.
  assign rd_fifo   = active & ~out_fifo_empty & ~rd_pend & (~m_valid | m_ready) & (rd_cnt < m_len);

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_pend     <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      M_minus_one <= '0;
      load_cnt    <= '0;
      rd_cnt      <= '0;
      del_cnt     <= '0;
    end else begin
      rd_pend <= rd_fifo;
      if (rd_pend) begin
        m_data  <= dout;
        m_valid <= 1'b1;
      end else if (xfer) begin
        m_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            M_minus_one <= m_len_minus_one;
            load_cnt    <= '0;
            rd_cnt      <= '0;
            del_cnt     <= '0;
            state       <= LOAD;
          end
        end
        LOAD: begin
          if (wr_fifo) load_cnt <= load_cnt + 9'd1;
          if (rd_fifo) rd_cnt <= rd_cnt + 9'd1;
          del_cnt <= del_next;
          if (last_push) state <= (del_next == m_len) ? DONE : DRAIN;
        end
        DRAIN: begin
          if (rd_fifo) rd_cnt <= rd_cnt + 9'd1;
          del_cnt <= del_next;
          if (del_next == m_len) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subsys_host.sv
// Scoreboard bench for subsys_host with a behavioural subsystem model (result = operand ^ MASK).
module tb_subsys_host;
  localparam int BW = 64;
  localparam logic [BW-1:0] MASK = 64'hA5A5_5A5A_0F0F_F0F0;

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    m_len_minus_one = 8'd0;
  logic          busy, done;
  logic [BW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [BW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [7:0]    M_minus_one;
  logic [BW-1:0] din;
  logic          wr_fifo;
  logic          in_fifo_full = 1'b0;
  logic          rd_fifo;
  logic [BW-1:0] dout = '0;
  logic          out_fifo_empty;

  subsys_host dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .m_len_minus_one(m_len_minus_one),
    .busy(busy), .done(done), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .M_minus_one(M_minus_one),
    .din(din), .wr_fifo(wr_fifo), .in_fifo_full(in_fifo_full), .rd_fifo(rd_fifo),
    .dout(dout), .out_fifo_empty(out_fifo_empty)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;
  int n_push = 0, n_pop = 0, n_done = 0;
  logic [BW-1:0] exp_in[$];
  logic [BW-1:0] exp_out[$];

  // Subsystem model: output FIFO holds transformed operands, dout valid the cycle after a pop.
  logic [BW-1:0] mq[$];
  int            occ = 0;
  assign out_fifo_empty = (occ == 0);

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      occ <= 0;
    end else begin
      if (rd_fifo && mq.size() > 0) dout <= mq.pop_front();
      if (wr_fifo) mq.push_back(din ^ MASK);
      occ <= occ + (wr_fifo ? 1 : 0) - (rd_fifo ? 1 : 0);
    end
  end

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a push or a delivered beat.
  logic          stall_prev = 1'b0;
  logic [BW-1:0] data_prev = '0;
  always @(negedge sys_clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (wr_fifo) begin
        n_push++;
        if (exp_in.size() == 0) check("push_unexpected", 1'b1, 1'b0);
        else check("din", din, exp_in.pop_front());
      end
      if (in_fifo_full) check("wr_while_full", wr_fifo, 1'b0);
      if (rd_fifo) n_pop++;
      if (done) n_done++;
      if (stall_prev) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_data", m_data, data_prev);
      end
      if (m_valid && !m_ready) check("rd_during_stall", rd_fifo, 1'b0);
      if (m_valid && m_ready) begin
        if (exp_out.size() == 0) check("beat_unexpected", 1'b1, 1'b0);
        else check("m_data", m_data, exp_out.pop_front());
      end
      stall_prev = m_valid & ~m_ready;
      data_prev  = m_data;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] len_m1);
    start = 1'b1;
    m_len_minus_one = len_m1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [BW-1:0] d);
    int   t = 0;
    logic acc = 1'b0;
    exp_in.push_back(d);
    exp_out.push_back(d ^ MASK);
    s_data = d;
    s_valid = 1'b1;
    while (!acc && t < 100) begin
      @(negedge sys_clk);
      acc = s_ready;
      tick();
      t++;
    end
    s_valid = 1'b0;
    check("send_accept", acc, 1'b1);
  endtask

  task automatic clear_counts();
    n_push = 0;
    n_pop = 0;
    n_done = 0;
  endtask

  task automatic finish_job(input string tag, input int m);
    int t = 0;
    do begin
      @(negedge sys_clk);
      t++;
    end while (busy && t < 2000);
    check({tag, "_busy_end"}, busy, 1'b0);
    check({tag, "_pushes"}, n_push, m);
    check({tag, "_pops"}, n_pop, m);
    check({tag, "_done_cnt"}, n_done, 1);
    check({tag, "_left"}, exp_out.size(), 0);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_m_valid"}, m_valid, 1'b0);
    check({tag, "_m_data"}, m_data, '0);
    check({tag, "_M_minus_one"}, M_minus_one, 8'd0);
    check({tag, "_s_ready"}, s_ready, 1'b0);
    check({tag, "_wr_fifo"}, wr_fifo, 1'b0);
    check({tag, "_rd_fifo"}, rd_fifo, 1'b0);
  endtask

  initial begin
    logic [BW-1:0] held;
    int t;
    #2;
    check_reset_outputs("rst");
    tick();
    rst_n = 1'b1;
    tick();

    // Basic 4-beat job.
    clear_counts();
    do_start(8'd3);
    @(negedge sys_clk);
    check("basic_M_minus_one", M_minus_one, 8'd3);
    check("basic_busy", busy, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) send(64'h1111_0000_0000_0000 + 64'(i) * 64'h0101);
    finish_job("basic", 4);

    // Input backpressure: in_fifo_full held for 5 cycles mid-load.
    clear_counts();
    do_start(8'd5);
    send(64'h2000_0000_0000_00A0);
    send(64'h2000_0000_0000_00A1);
    in_fifo_full = 1'b1;
    fork
      send(64'h2000_0000_0000_00A2);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge sys_clk);
          check("bp_in_s_ready", s_ready, 1'b0);
          check("bp_in_wr_fifo", wr_fifo, 1'b0);
          tick();
        end
        in_fifo_full = 1'b0;
      end
    join
    for (int i = 3; i < 6; i++) send(64'h2000_0000_0000_00A0 + 64'(i));
    finish_job("bp_in", 6);

    // Output backpressure: m_ready low for 10 cycles with a beat presented.
    clear_counts();
    m_ready = 1'b0;
    do_start(8'd3);
    for (int i = 0; i < 4; i++) send(64'hC0DE_0000_0000_0000 | 64'(i * 7 + 1));
    t = 0;
    while (!m_valid && t < 50) begin
      @(negedge sys_clk);
      t++;
    end
    check("bp_out_valid_seen", m_valid, 1'b1);
    @(negedge sys_clk);
    held = m_data;
    check("bp_out_first", held, (64'hC0DE_0000_0000_0001 ^ MASK));
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      check("bp_out_stable", m_data, held);
      check("bp_out_rd_fifo", rd_fifo, 1'b0);
    end
    tick();
    m_ready = 1'b1;
    finish_job("bp_out", 4);

    // Start pulsed while busy must not alter the job.
    clear_counts();
    do_start(8'd2);
    send(64'h3333_0000_0000_0001);
    do_start(8'd7);
    @(negedge sys_clk);
    check("busy_start_M_minus_one", M_minus_one, 8'd2);
    tick();
    send(64'h3333_0000_0000_0002);
    send(64'h3333_0000_0000_0003);
    finish_job("busy_start", 3);

    // Maximum job length.
    clear_counts();
    do_start(8'd255);
    for (int i = 0; i < 256; i++) send(64'h4400_0000_0000_0000 + 64'(i) * 64'h0001_0001);
    finish_job("max", 256);

    // Reset while stalled in DRAIN, then a one-beat job.
    clear_counts();
    m_ready = 1'b0;
    do_start(8'd3);
    for (int i = 0; i < 4; i++) send(64'h5500_0000_0000_0010 + 64'(i));
    repeat (4) tick();
    check("mid_busy", busy, 1'b1);
    check("mid_s_ready", s_ready, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    exp_in.delete();
    exp_out.delete();
    tick();
    tick();
    rst_n = 1'b1;
    m_ready = 1'b1;
    tick();
    clear_counts();
    do_start(8'd0);
    send(64'h6666_7777_8888_9999);
    finish_job("after_rst", 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
